// File: rtl/branch_pc_if.sv
// Interface: branch_pc_if
// Groups the decode-side control/operand inputs and the PC-stage outputs of
// branch_pc_unit.
//   master : drives pc_en, branch, zero, jump, branch_offset, jump_index;
//            observes pc, pc_plus4, branch_target, redirect, misaligned
//   slave  : the PC unit side (mirror of master)
interface branch_pc_if;
    logic        pc_en;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        redirect;
    logic        misaligned;

    modport master (
        output pc_en, branch, zero, jump, branch_offset, jump_index,
        input  pc, pc_plus4, branch_target, redirect, misaligned
    );

    modport slave (
        input  pc_en, branch, zero, jump, branch_offset, jump_index,
        output pc, pc_plus4, branch_target, redirect, misaligned
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Module: branch_pc_unit
// Program-counter stage. Holds the PC register, computes pc+4, branch target
// (pc+4 + pre-shifted offset) and jump target, and selects the next PC each
// cycle. A redirect requested while stalled is parked and applied on the
// first cycle the PC may advance again, so it is never lost.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : branch_pc_if.slave
//            in  pc_en, branch, zero, jump, branch_offset[31:0], jump_index[25:0]
//            out pc[31:0] (registered), pc_plus4, branch_target (combinational),
//                redirect, misaligned (registered one-cycle pulses)
// Configuration macro: PC_ALIGN_CHECK_EN
//   defined   : a target with [1:0]!=0 loads TRAP_VECTOR and pulses misaligned
//   undefined : target[1:0] is cleared before loading, misaligned tied 0
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic       clk,
    input  logic       rst_n,
    branch_pc_if.slave bus
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] pend_q, pend_nxt;
    logic        redirect_q, misaligned_q;

    logic [31:0] pc_plus4, branch_target, jump_target, sel_target;
    logic [31:0] load_src, load_pc;
    logic        req, load, advance, load_mis;

    // Datapath: all adds wrap modulo 2^32.
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + bus.branch_offset;
    assign jump_target   = {pc_plus4[31:28], bus.jump_index, 2'b00};
    assign req           = bus.jump | (bus.branch & bus.zero);
    // Jump wins over a simultaneously taken branch.
    assign sel_target    = bus.jump ? jump_target : branch_target;

    // Alignment handling of whichever target is being loaded (live or parked).
    always_comb begin
`ifdef PC_ALIGN_CHECK_EN
        load_mis = (load_src[1:0] != 2'b00);
        load_pc  = load_mis ? TRAP_VECTOR : load_src;
`else
        load_mis = 1'b0;
        load_pc  = {load_src[31:2], 2'b00};
`endif
    end

    // Next-state / load-select logic.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_q;
        load      = 1'b0;
        advance   = 1'b0;
        load_src  = sel_target;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (bus.pc_en) begin
                    load    = req;
                    advance = ~req;
                end else if (req) begin
                    pend_nxt  = sel_target;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                // Later requests are ignored; the first parked target wins.
                load_src = pend_q;
                if (bus.pc_en) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign pc_nxt = load ? load_pc : (advance ? pc_plus4 : pc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc_q         <= RESET_PC;
            pend_q       <= 32'h0;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc_q         <= pc_nxt;
            pend_q       <= pend_nxt;
            redirect_q   <= load;
            misaligned_q <= load & load_mis;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.branch_target = branch_target;
    assign bus.redirect      = redirect_q;
    assign bus.misaligned    = misaligned_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Testbench: tb_branch_pc_unit
// Directed stimulus for branch_pc_unit with a behavioural reference model
// (pending redirect kept as a queue) compared on every falling edge, plus
// hand-computed literal expectations at key points.
module tb_branch_pc_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst_n;
    branch_pc_if bus();

    branch_pc_unit #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic        m_redir, m_mis, m_booted;
    logic [31:0] m_pend[$];

    // Returns {misaligned, pc_to_load} for a requested target.
    function automatic logic [32:0] fix(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return (t % 4 != 0) ? {1'b1, TRAP_VECTOR} : {1'b0, t};
`else
        return {1'b0, t - (t % 4)};
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] p4, tgt;
        logic [32:0] r;
        if (!rst_n) begin
            m_pc     <= RESET_PC;
            m_redir  <= 1'b0;
            m_mis    <= 1'b0;
            m_booted <= 1'b0;
            m_pend.delete();
        end else if (!m_booted) begin
            m_booted <= 1'b1;
            m_redir  <= 1'b0;
            m_mis    <= 1'b0;
        end else begin
            p4  = m_pc + 4;
            tgt = bus.jump ? {p4[31:28], bus.jump_index, 2'b00} : p4 + bus.branch_offset;
            m_redir <= 1'b0;
            m_mis   <= 1'b0;
            if (m_pend.size() != 0) begin
                if (bus.pc_en) begin
                    r = fix(m_pend[0]);
                    m_pc <= r[31:0]; m_mis <= r[32]; m_redir <= 1'b1;
                    m_pend.delete();
                end
            end else if (bus.pc_en) begin
                if (bus.jump || (bus.branch && bus.zero)) begin
                    r = fix(tgt);
                    m_pc <= r[31:0]; m_mis <= r[32]; m_redir <= 1'b1;
                end else begin
                    m_pc <= p4;
                end
            end else if (bus.jump || (bus.branch && bus.zero)) begin
                m_pend.push_back(tgt);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc",            bus.pc,            m_pc);
            chk("pc_plus4",      bus.pc_plus4,      m_pc + 32'd4);
            chk("branch_target", bus.branch_target, m_pc + 32'd4 + bus.branch_offset);
            chk("redirect",      {31'h0, bus.redirect},   {31'h0, m_redir});
            chk("misaligned",    {31'h0, bus.misaligned}, {31'h0, m_mis});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.branch = 1'b0; bus.zero = 1'b0; bus.jump = 1'b0;
        bus.branch_offset = 32'h0; bus.jump_index = 26'h0;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.pc_en = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        chk("reset pc", bus.pc, 32'h0);
        chk("reset redirect", {31'h0, bus.redirect}, 32'h0);

        // 1: reset release, boot cycle then sequential fetch
        rst_n = 1'b1;
        tick(); chk("boot pc", bus.pc, 32'h0);
        tick(); chk("seq pc 4", bus.pc, 32'h4);
        tick(); chk("seq pc 8", bus.pc, 32'h8);
        tick(); chk("seq pc C", bus.pc, 32'hC);
        tick(); chk("seq pc 10", bus.pc, 32'h10);

        // 2: taken branch from 0x10
        bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 32'h20;
        #1 chk("bt at 10", bus.branch_target, 32'h34);
        tick(); chk("taken pc", bus.pc, 32'h34);
        chk("taken redirect", {31'h0, bus.redirect}, 32'h1);
        idle();
        tick(); chk("after taken pc", bus.pc, 32'h38);
        chk("redirect one cycle", {31'h0, bus.redirect}, 32'h0);
        // back to 0x10 via jump, then a not-taken branch
        bus.jump = 1'b1; bus.jump_index = 26'h4;
        tick(); chk("jump to 10", bus.pc, 32'h10);
        idle(); bus.branch = 1'b1; bus.zero = 1'b0; bus.branch_offset = 32'h20;
        tick(); chk("not taken pc", bus.pc, 32'h14);
        chk("not taken redirect", {31'h0, bus.redirect}, 32'h0);

        // 3: reach 0x1000_0000, then jump + taken branch together
        idle(); bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 32'h0FFF_FFE8;
        tick(); chk("branch far", bus.pc, 32'h1000_0000);
        bus.jump = 1'b1; bus.jump_index = 26'h40; bus.branch_offset = 32'h20;
        tick(); chk("jump wins", bus.pc, 32'h1000_0100);

        // 4: stalled redirect, first target wins
        idle(); bus.pc_en = 1'b0;
        bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 32'hEFFF_FFFC;
        tick(); chk("stall hold 1", bus.pc, 32'h1000_0100);
        bus.branch_offset = 32'hF000_00FC;
        tick(); chk("stall hold 2", bus.pc, 32'h1000_0100);
        bus.branch_offset = 32'hEFFF_FFFC;
        tick(); chk("stall hold 3", bus.pc, 32'h1000_0100);
        chk("stall no redirect", {31'h0, bus.redirect}, 32'h0);
        idle(); bus.pc_en = 1'b1;
        tick(); chk("pend released", bus.pc, 32'h100);
        chk("pend redirect", {31'h0, bus.redirect}, 32'h1);

        // 5: wrap, then reset while a redirect is pending
        bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 32'hFFFF_FEF8;
        tick(); chk("pc top", bus.pc, 32'hFFFF_FFFC);
        idle();
        #1 chk("pc_plus4 wrap", bus.pc_plus4, 32'h0);
        tick(); chk("wrap pc", bus.pc, 32'h0);
        tick(); chk("post wrap pc", bus.pc, 32'h4);
        bus.pc_en = 1'b0; bus.jump = 1'b1; bus.jump_index = 26'h100;
        tick(); chk("pend hold", bus.pc, 32'h4);
        rst_n = 1'b0;
        #1 chk("async reset pc", bus.pc, RESET_PC);
        chk("async reset redirect", {31'h0, bus.redirect}, 32'h0);
        idle(); bus.pc_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); chk("boot after reset", bus.pc, 32'h0);

        // 6: misaligned target from pc=0
        bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 32'h2;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("misaligned pc", bus.pc, TRAP_VECTOR);
        chk("misaligned flag", {31'h0, bus.misaligned}, 32'h1);
`else
        chk("aligned-down pc", bus.pc, 32'h4);
        chk("misaligned flag", {31'h0, bus.misaligned}, 32'h0);
`endif
        chk("misaligned redirect", {31'h0, bus.redirect}, 32'h1);
        // misaligned target parked during a stall
        bus.pc_en = 1'b0; bus.branch_offset = 32'h1;
        tick();
        idle(); bus.pc_en = 1'b1;
        tick();
        tick();
        tick();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
